trena_uc_sequenciador: RTL

//  Control unit for the digital tape measure, the parametrised successor of the fixed 3-digit UC.

---
 rtl/trena_uc_sequenciador.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/trena_uc_sequenciador.sv
// Tape-measure control unit: triggers one measurement, then sends N_DIGITS + N_TRAILER
// characters through the serial TX. Includes a measurement timeout and a continuous mode.
module trena_uc_sequenciador #(
  parameter int N_DIGITS        = 3,
  parameter int N_TRAILER       = 1,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int INTERVAL_CYCLES = 25_000_000,
  localparam int N_CHARS = N_DIGITS + N_TRAILER,
  localparam int SEL_W   = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mensurar,
  input  logic             continuo,
  input  logic             medida_pronto,
  input  logic             envio_pronto,
  output logic             medir,
  output logic             transmitir,
  output logic [SEL_W-1:0] sel_caractere,
  output logic             pronto,
  output logic             erro_medida,
  output logic [3:0]       db_estado
);

  // One counter is shared by the timeout and the inter-measurement gap.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INTERVAL_CYCLES) ? TIMEOUT_CYCLES : INTERVAL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTERVAL_LAST = CNT_W'(INTERVAL_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST      = SEL_W'(N_CHARS - 1);

  typedef enum logic [3:0] {
    INICIAL            = 4'h0,
    FAZ_MEDIDA         = 4'h1,
    AGUARDA_MEDIDA     = 4'h2,
    TRANSMITE          = 4'h3,
    ESPERA_TRANSMISSAO = 4'h4,
    ESPERA_INTERVALO   = 4'h6,
    ERRO               = 4'hE,
    FIM                = 4'hF
  } estado_t;

  estado_t          estado_reg;
  logic [SEL_W-1:0] idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             medir_reg;
  logic             transmitir_reg;
  logic             pronto_reg;
  logic             erro_reg;

  // Pulse outputs are set on the transition into their state, so they are high
  // for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg     <= INICIAL;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      medir_reg      <= 1'b0;
      transmitir_reg <= 1'b0;
      pronto_reg     <= 1'b0;
      erro_reg       <= 1'b0;
    end else begin
      medir_reg      <= 1'b0;
      transmitir_reg <= 1'b0;
      pronto_reg     <= 1'b0;
      case (estado_reg)
        INICIAL: begin
          if (mensurar) begin
            estado_reg <= FAZ_MEDIDA;
            medir_reg  <= 1'b1;
            erro_reg   <= 1'b0;
          end
        end
        FAZ_MEDIDA: begin
          cnt_reg    <= '0;
          idx_reg    <= '0;
          estado_reg <= AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          if (medida_pronto) begin
            estado_reg     <= TRANSMITE;
            transmitir_reg <= 1'b1;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            estado_reg <= ERRO;
            erro_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        TRANSMITE: begin
          estado_reg <= ESPERA_TRANSMISSAO;
        end
        ESPERA_TRANSMISSAO: begin
          if (envio_pronto) begin
            if (idx_reg == IDX_LAST) begin
              estado_reg <= FIM;
              pronto_reg <= 1'b1;
            end else begin
              idx_reg        <= idx_reg + SEL_W'(1);
              estado_reg     <= TRANSMITE;
              transmitir_reg <= 1'b1;
            end
          end
        end
        ESPERA_INTERVALO: begin
          if (!continuo) begin
            estado_reg <= INICIAL;
          end else if (cnt_reg == INTERVAL_LAST) begin
            estado_reg <= FAZ_MEDIDA;
            medir_reg  <= 1'b1;
            erro_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ERRO: begin
          estado_reg <= INICIAL;
        end
        FIM: begin
          if (continuo) begin
            cnt_reg    <= '0;
            estado_reg <= ESPERA_INTERVALO;
          end else begin
            estado_reg <= INICIAL;
          end
        end
        default: begin
          estado_reg <= INICIAL;
        end
      endcase
    end
  end

  assign medir         = medir_reg;
  assign transmitir    = transmitir_reg;
  assign pronto        = pronto_reg;
  assign erro_medida   = erro_reg;
  assign sel_caractere = idx_reg;
  assign db_estado     = estado_reg;

endmodule
